// File: rtl/sound_player.sv
// rtl/sound_player.sv - multi-clip sample ROM player feeding the audio controller
module sound_player #(
  parameter int ADDR_W      = 18,
  parameter int SAMPLE_W    = 6,
  parameter int OUT_W       = 32,
  parameter int NUM_CLIPS   = 4,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START =
    {18'd83255, 18'd66983, 18'd16396, 18'd0},
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END =
    {18'd137138, 18'd83254, 18'd66982, 18'd16395},
  parameter int DIV         = 1200,
  parameter int ROM_LATENCY = 1,
  parameter int STEREO      = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                play,
  input  logic [((NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1)-1:0] clip_sel,
  input  logic                loop,
  input  logic                stop,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [OUT_W-1:0]    left_channel_audio_out,
  output logic [OUT_W-1:0]    right_channel_audio_out,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(DIV - 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic                loop_q, loop_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                done_q, done_d;

  logic [ADDR_W-1:0]   sel_start;
  logic [ADDR_W-1:0]   sel_end;
  logic                sel_ok;
  logic                restart;

  // Look up the requested clip's range; out-of-range selects are flagged invalid
  always_comb begin
    sel_start = '0;
    sel_end   = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (32'(clip_sel) == i) begin
        sel_start = CLIP_START[i*ADDR_W +: ADDR_W];
        sel_end   = CLIP_END[i*ADDR_W +: ADDR_W];
        sel_ok    = 1'b1;
      end
    end
  end

  assign restart = play && sel_ok;

  // Next-state and datapath: stop beats play, a valid play beats everything else
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    start_addr_d    = start_addr_q;
    end_addr_d      = end_addr_q;
    loop_d          = loop_q;
    sample_d        = sample_q;
    div_cnt_d       = (div_cnt_q == DIV_MAX) ? div_cnt_q : div_cnt_q + CNT_W'(1);
    lat_cnt_d       = lat_cnt_q;
    done_d          = 1'b0;
    write_audio_out = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
    end else if (restart) begin
      cur_addr_d   = sel_start;
      start_addr_d = sel_start;
      end_addr_d   = sel_end;
      loop_d       = loop;
      div_cnt_d    = '0;
      lat_cnt_d    = '0;
      state_d      = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (lat_cnt_q == LAT_MAX) begin
            sample_d = rom_q;
            state_d  = S_WRITE;
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
        end
        S_WRITE: begin
          if (audio_out_allowed) begin
            write_audio_out = 1'b1;
            state_d         = S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_cnt_q == DIV_MAX) begin
            if (cur_addr_q != end_addr_q) begin
              cur_addr_d = cur_addr_q + ADDR_W'(1);
              div_cnt_d  = '0;
              lat_cnt_d  = '0;
              state_d    = S_FETCH;
            end else if (loop_q) begin
              cur_addr_d = start_addr_q;
              div_cnt_d  = '0;
              lat_cnt_d  = '0;
              state_d    = S_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      loop_q       <= 1'b0;
      sample_q     <= '0;
      div_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      loop_q       <= loop_d;
      sample_q     <= sample_d;
      div_cnt_q    <= div_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr                = cur_addr_q;
  assign busy                    = (state_q != S_IDLE);
  assign done                    = done_q;
  assign left_channel_audio_out  = {sample_q, {(OUT_W-SAMPLE_W){1'b0}}};
  assign right_channel_audio_out = (STEREO != 0) ? left_channel_audio_out : '0;

endmodule

// File: tb/tb_sound_player.sv
// tb/tb_sound_player.sv - directed bench for sound_player
module tb_sound_player;

  localparam int ADDR_W    = 18;
  localparam int SAMPLE_W  = 6;
  localparam int OUT_W     = 32;
  localparam int NUM_CLIPS = 3;
  localparam logic [NUM_CLIPS*ADDR_W-1:0] STARTS = {18'd40, 18'd10, 18'd0};
  localparam logic [NUM_CLIPS*ADDR_W-1:0] ENDS   = {18'd45, 18'd13, 18'd5};

  logic                clk = 1'b0;
  logic                reset;
  logic                play;
  logic [1:0]          clip_sel;
  logic                loop;
  logic                stop;
  logic                allowed;

  logic [ADDR_W-1:0]   rom_addr, m_rom_addr;
  logic [SAMPLE_W-1:0] rom_q, m_rom_q;
  logic                wr, m_wr;
  logic [OUT_W-1:0]    left, right, m_left, m_right;
  logic                busy, m_busy;
  logic                done, m_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          addr_cyc[$];
  int          addr_val[$];
  int          wr_cyc[$];
  logic [31:0] wr_l[$];
  int          done_cyc[$];
  int          busy_fall[$];
  logic [ADDR_W-1:0] last_addr = '0;
  logic              prev_busy = 1'b0;

  function automatic logic [SAMPLE_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[5:0] ^ 6'h2A;
  endfunction

  assign rom_q   = rom_fn(rom_addr);
  assign m_rom_q = rom_fn(m_rom_addr);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sound_player #(
    .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .NUM_CLIPS(NUM_CLIPS),
    .CLIP_START(STARTS), .CLIP_END(ENDS), .DIV(8), .ROM_LATENCY(1), .STEREO(1)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .play(play), .clip_sel(clip_sel), .loop(loop),
    .stop(stop), .rom_addr(rom_addr), .rom_q(rom_q), .audio_out_allowed(allowed),
    .write_audio_out(wr), .left_channel_audio_out(left),
    .right_channel_audio_out(right), .busy(busy), .done(done)
  );

  sound_player #(
    .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .NUM_CLIPS(NUM_CLIPS),
    .CLIP_START(STARTS), .CLIP_END(ENDS), .DIV(8), .ROM_LATENCY(1), .STEREO(0)
  ) dut_mono (
    .CLOCK_50(clk), .reset(reset), .play(play), .clip_sel(clip_sel), .loop(loop),
    .stop(stop), .rom_addr(m_rom_addr), .rom_q(m_rom_q), .audio_out_allowed(allowed),
    .write_audio_out(m_wr), .left_channel_audio_out(m_left),
    .right_channel_audio_out(m_right), .busy(m_busy), .done(m_done)
  );

  // Event log sampled mid-cycle, tagged with the number of rising edges so far
  always @(negedge clk) begin
    if (wr) begin
      wr_cyc.push_back(cyc);
      wr_l.push_back(left);
    end
    if (rom_addr != last_addr) begin
      addr_cyc.push_back(cyc);
      addr_val.push_back(int'(rom_addr));
    end
    if (done) done_cyc.push_back(cyc);
    if (prev_busy && !busy) busy_fall.push_back(cyc);
    last_addr <= rom_addr;
    prev_busy <= busy;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] ql(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'h0BAD_0BAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic clear_logs();
    addr_cyc.delete();
    addr_val.delete();
    wr_cyc.delete();
    wr_l.delete();
    done_cyc.delete();
    busy_fall.delete();
  endtask

  task automatic start_clip(input int sel, input logic lp, output int t);
    clip_sel = 2'(sel);
    loop     = lp;
    play     = 1'b1;
    t        = cyc + 1;
    tick(1);
    play     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    logic [31:0] exp_l [4];
    exp_l[0] = 32'h8000_0000;
    exp_l[1] = 32'h8400_0000;
    exp_l[2] = 32'h9800_0000;
    exp_l[3] = 32'h9C00_0000;

    reset = 1'b1; play = 1'b0; clip_sel = 2'd0; loop = 1'b0; stop = 1'b0; allowed = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_left", 64'(left), 64'd0);
    check("rst_right", 64'(right), 64'd0);
    check("rst_write", 64'(wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // asynchronous reset in the middle of a write
    clear_logs();
    start_clip(1, 1'b0, t);
    wait_cyc(t + 1);
    check("pre_rst_write", 64'(wr), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_write", 64'(wr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_addr", 64'(rom_addr), 64'd0);
    check("mid_rst_left", 64'(left), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    tick(2);
    reset = 1'b0;
    clear_logs();
    wait_cyc(cyc + 40);
    check("post_rst_writes", 64'(wr_cyc.size()), 64'd0);
    check("post_rst_dones", 64'(done_cyc.size()), 64'd0);

    // one-shot clip 1 = [10,13]
    clear_logs();
    start_clip(1, 1'b0, t);
    check("os_first_addr", 64'(rom_addr), 64'd10);
    check("os_first_busy", 64'(busy), 64'd1);
    wait_cyc(t + 40);
    check("os_addr_count", 64'(addr_cyc.size()), 64'd4);
    check("os_wr_count", 64'(wr_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("os_addr_val%0d", i), 64'(qi(addr_val, i)), 64'(10 + i));
      check($sformatf("os_addr_cyc%0d", i), 64'(qi(addr_cyc, i)), 64'(t + 8*i));
      check($sformatf("os_wr_cyc%0d", i), 64'(qi(wr_cyc, i)), 64'(t + 1 + 8*i));
      check($sformatf("os_wr_data%0d", i), 64'(ql(wr_l, i)), 64'(exp_l[i]));
    end
    check("os_done_count", 64'(done_cyc.size()), 64'd1);
    check("os_done_cyc", 64'(qi(done_cyc, 0)), 64'(t + 32));
    check("os_busy_fall", 64'(qi(busy_fall, 0)), 64'(t + 32));
    check("os_busy_end", 64'(busy), 64'd0);

    // loop mode then stop
    clear_logs();
    start_clip(1, 1'b1, t);
    wait_cyc(t + 44);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("lp_stop_busy", 64'(busy), 64'd0);
    wait_cyc(t + 70);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lp_addr_val%0d", i), 64'(qi(addr_val, i)), 64'(10 + (i % 4)));
      check($sformatf("lp_addr_cyc%0d", i), 64'(qi(addr_cyc, i)), 64'(t + 8*i));
    end
    check("lp_wr_count", 64'(wr_cyc.size()), 64'd6);
    check("lp_done_count", 64'(done_cyc.size()), 64'd0);
    check("lp_idle_addr", 64'(rom_addr), 64'd11);

    // backpressure on the sample at address 11
    clear_logs();
    start_clip(1, 1'b0, t);
    wait_cyc(t + 8);
    allowed = 1'b0;
    wait_cyc(t + 28);
    check("bp_hold_addr", 64'(rom_addr), 64'd11);
    check("bp_held_writes", 64'(wr_cyc.size()), 64'd1);
    allowed = 1'b1;
    wait_cyc(t + 50);
    check("bp_wr_count", 64'(wr_cyc.size()), 64'd4);
    check("bp_wr1_cyc", 64'(qi(wr_cyc, 1)), 64'(t + 28));
    check("bp_wr1_data", 64'(ql(wr_l, 1)), 64'(exp_l[1]));
    check("bp_wr2_data", 64'(ql(wr_l, 2)), 64'(exp_l[2]));
    check("bp_addr12_cyc", 64'(qi(addr_cyc, 2)), 64'(t + 30));
    check("bp_addr12_val", 64'(qi(addr_val, 2)), 64'd12);
    check("bp_addr13_cyc", 64'(qi(addr_cyc, 3)), 64'(t + 38));
    check("bp_done_cyc", 64'(qi(done_cyc, 0)), 64'(t + 46));

    // retrigger, play+stop collision, invalid clip select
    clear_logs();
    start_clip(1, 1'b0, t);
    wait_cyc(t + 12);
    start_clip(2, 1'b0, t2);
    check("rt_addr", 64'(rom_addr), 64'd40);
    check("rt_busy", 64'(busy), 64'd1);
    clip_sel = 2'd1; play = 1'b1; stop = 1'b1;
    tick(1);
    play = 1'b0; stop = 1'b0;
    check("ps_busy", 64'(busy), 64'd0);
    check("ps_addr", 64'(rom_addr), 64'd40);
    start_clip(3, 1'b0, t2);
    check("inv_busy", 64'(busy), 64'd0);
    check("inv_addr", 64'(rom_addr), 64'd40);
    wait_cyc(cyc + 20);
    check("rt_wr_count", 64'(wr_cyc.size()), 64'd2);
    check("rt_done_count", 64'(done_cyc.size()), 64'd0);

    // retrigger at end of clip, then channel data for rom_q = 6'h2A
    clear_logs();
    start_clip(1, 1'b0, t);
    wait_cyc(t + 31);
    start_clip(0, 1'b0, t2);
    check("re_busy", 64'(busy), 64'd1);
    check("re_addr", 64'(rom_addr), 64'd0);
    wait_cyc(t2 + 1);
    @(negedge clk);
    check("ch_write", 64'(wr), 64'd1);
    check("ch_left", 64'(left), 64'hA800_0000);
    check("ch_right_stereo", 64'(right), 64'hA800_0000);
    check("ch_left_mono", 64'(m_left), 64'hA800_0000);
    check("ch_right_mono", 64'(m_right), 64'd0);
    tick(1);
    wait_cyc(t2 + 55);
    check("re_done_count", 64'(done_cyc.size()), 64'd1);
    check("re_done_cyc", 64'(qi(done_cyc, 0)), 64'(t2 + 48));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
